// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared types, defaults and sizing helper for the req/ack responder
package req_ack_pkg;

  typedef enum logic {
    REQ_ACK_IDLE = 1'b0,
    REQ_ACK_BUSY = 1'b1
  } req_ack_state_e;

  localparam int REQ_ACK_DELAY_DEF   = 4;
  localparam int REQ_ACK_MIN_GAP_DEF = 8;

  // Gap counter spans 0..min_gap-1; never narrower than one bit.
  function automatic int req_ack_cnt_w(input int min_gap);
    return (min_gap > 2) ? $clog2(min_gap) : 1;
  endfunction

endpackage

// File: rtl/req_ack_gap_timer.sv
// rtl/req_ack_gap_timer.sv - gap counter with load/increment and ack/gap terminal decode
module req_ack_gap_timer
  import req_ack_pkg::*;
#(
  parameter int ACK_DELAY = REQ_ACK_DELAY_DEF,
  parameter int MIN_GAP   = REQ_ACK_MIN_GAP_DEF,
  parameter int CW        = req_ack_cnt_w(MIN_GAP)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_ack_hit,
  output logic o_gap_done
);

  localparam logic [CW-1:0] ACK_V  = CW'(ACK_DELAY);
  localparam logic [CW-1:0] LAST_V = CW'(MIN_GAP - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(1);
    end else if (o_gap_done) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_ack_hit  = i_run && (r_cnt == ACK_V);
  assign o_gap_done = i_run && (r_cnt == LAST_V);

endmodule

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - req/ack responder with spacing enforcement and event counters
// Optional embedded properties: define REQ_ACK_RESP_FORMAL_EN.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int ACK_DELAY = REQ_ACK_DELAY_DEF,
  parameter int MIN_GAP   = REQ_ACK_MIN_GAP_DEF,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             err_clr,
  output logic             ack,
  output logic             busy,
  output logic             err_spacing,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] ack_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int CW = req_ack_cnt_w(MIN_GAP);

  req_ack_state_e r_state;
  req_ack_state_e w_state_next;

  logic             w_busy;
  logic             w_accept;
  logic             w_violation;
  logic             w_ack_hit;
  logic             w_gap_done;
  logic             r_err;
  logic [CNT_W-1:0] r_req_count;
  logic [CNT_W-1:0] r_ack_count;
  logic [CNT_W-1:0] r_drop_count;

  assign w_busy      = (r_state == REQ_ACK_BUSY);
  assign w_accept    = !w_busy && req;
  assign w_violation = w_busy && req;

  req_ack_gap_timer #(
    .ACK_DELAY (ACK_DELAY),
    .MIN_GAP   (MIN_GAP),
    .CW        (CW)
  ) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_run      (w_busy),
    .o_ack_hit  (w_ack_hit),
    .o_gap_done (w_gap_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= REQ_ACK_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      REQ_ACK_IDLE: if (req) w_state_next = REQ_ACK_BUSY;
      REQ_ACK_BUSY: if (w_gap_done) w_state_next = REQ_ACK_IDLE;
      default:      w_state_next = REQ_ACK_IDLE;
    endcase
  end

  // A violation on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_req_count  <= '0;
      r_ack_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_violation) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_accept)    r_req_count  <= r_req_count + CNT_W'(1);
      if (w_ack_hit)   r_ack_count  <= r_ack_count + CNT_W'(1);
      if (w_violation) r_drop_count <= r_drop_count + CNT_W'(1);
    end
  end

  assign ack         = w_ack_hit;
  assign busy        = w_busy;
  assign err_spacing = r_err;
  assign req_count   = r_req_count;
  assign ack_count   = r_ack_count;
  assign drop_count  = r_drop_count;

`ifdef REQ_ACK_RESP_FORMAL_EN
  logic [7:0] r_f_cycles;
  logic       w_f_hist;

  initial r_f_cycles = 8'd0;

  always_ff @(posedge clk) begin
    if (r_f_cycles != 8'hFF) r_f_cycles <= r_f_cycles + 8'd1;
  end

  assign w_f_hist = (r_f_cycles >= 8'(ACK_DELAY));

  a_ack_has_req : assert property (@(posedge clk) disable iff (rst)
    (ack && w_f_hist) |-> $past(req, ACK_DELAY));
  a_ack_single : assert property (@(posedge clk) disable iff (rst)
    ack |=> !ack);
  a_count_inv : assert property (@(posedge clk) disable iff (rst)
    CNT_W'(req_count - ack_count) <= CNT_W'(1));
  c_two_req : cover property (@(posedge clk) req_count == CNT_W'(2));
  c_drop : cover property (@(posedge clk) drop_count >= CNT_W'(1));
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// tb/tb_req_ack_responder.sv - directed and randomized bench with an edge-arithmetic reference model
module tb_req_ack_responder;

  localparam int AD = 4;
  localparam int MG = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          err_clr = 1'b0;
  logic          ack;
  logic          busy;
  logic          err_spacing;
  logic [CW-1:0] req_count;
  logic [CW-1:0] ack_count;
  logic [CW-1:0] drop_count;

  int errors = 0;
  int checks = 0;

  req_ack_responder #(
    .ACK_DELAY (AD),
    .MIN_GAP   (MG),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .err_clr     (err_clr),
    .ack         (ack),
    .busy        (busy),
    .err_spacing (err_spacing),
    .req_count   (req_count),
    .ack_count   (ack_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: remembers the edge number of the last accepted request.
  int edge_n = 0;
  bit m_has  = 1'b0;
  int m_k    = 0;
  int m_req  = 0;
  int m_ack  = 0;
  int m_drop = 0;
  bit m_err  = 1'b0;
  bit mon_en = 1'b0;

  function automatic bit exp_busy(input int n);
    return m_has && (n >= m_k + 1) && (n <= m_k + MG - 1);
  endfunction

  function automatic bit exp_ack(input int n);
    return m_has && (n == m_k + AD);
  endfunction

  always @(posedge clk) begin : model
    bit b;
    bit a;
    edge_n++;
    if (rst) begin
      m_has = 1'b0; m_req = 0; m_ack = 0; m_drop = 0; m_err = 1'b0;
    end else begin
      b = exp_busy(edge_n);
      a = exp_ack(edge_n);
      if (a) m_ack++;
      if (req && b) begin
        m_drop++;
        m_err = 1'b1;
      end else begin
        if (req) begin
          m_has = 1'b1;
          m_k   = edge_n;
          m_req++;
        end
        if (err_clr) m_err = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    int n;
    if (mon_en && !rst) begin
      n = edge_n + 1;
      checks += 6;
      if (ack !== exp_ack(n)) begin
        errors++; $display("FAIL mon_ack edge %0d: got %b want %b", n, ack, exp_ack(n));
      end
      if (busy !== exp_busy(n)) begin
        errors++; $display("FAIL mon_busy edge %0d: got %b want %b", n, busy, exp_busy(n));
      end
      if (err_spacing !== m_err) begin
        errors++; $display("FAIL mon_err edge %0d: got %b want %b", n, err_spacing, m_err);
      end
      if (req_count !== CW'(m_req)) begin
        errors++; $display("FAIL mon_req_count edge %0d: got %0d want %0d", n, req_count, CW'(m_req));
      end
      if (ack_count !== CW'(m_ack)) begin
        errors++; $display("FAIL mon_ack_count edge %0d: got %0d want %0d", n, ack_count, CW'(m_ack));
      end
      if (drop_count !== CW'(m_drop)) begin
        errors++; $display("FAIL mon_drop_count edge %0d: got %0d want %0d", n, drop_count, CW'(m_drop));
      end
    end
  end

  task automatic cyc(input bit r, input bit c);
    @(negedge clk);
    req     = r;
    err_clr = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    req = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({ack, busy, err_spacing} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {ack, busy, err_spacing});
    end
    checks++;
    if ({req_count, ack_count, drop_count} !== '0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", req_count, ack_count, drop_count);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    cyc(1, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0);
      checks++;
      if (ack !== (i == AD)) begin
        errors++; $display("FAIL single_ack +%0d: got %b want %b", i, ack, (i == AD));
      end
      checks++;
      if (busy !== (i <= MG - 1)) begin
        errors++; $display("FAIL single_busy +%0d: got %b want %b", i, busy, (i <= MG - 1));
      end
    end
    checks++;
    if (req_count !== 3'd1 || ack_count !== 3'd1) begin
      errors++; $display("FAIL single_counts: got %0d/%0d want 1/1", req_count, ack_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, 0);
    for (int i = 1; i <= MG + AD + 1; i++) begin
      cyc(i == MG, 0);
      checks++;
      if (ack !== (i == AD || i == MG + AD)) begin
        errors++; $display("FAIL b2b_ack +%0d: got %b want %b", i, ack, (i == AD || i == MG + AD));
      end
    end
    checks++;
    if (req_count !== 3'd2 || ack_count !== 3'd2 || drop_count !== 3'd0 || err_spacing !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got req=%0d ack=%0d drop=%0d err=%b want 2 2 0 0",
               req_count, ack_count, drop_count, err_spacing);
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    cyc(1, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(i == 3, i == 10);
      checks++;
      if (ack !== (i == AD)) begin
        errors++; $display("FAIL drop_ack +%0d: got %b want %b", i, ack, (i == AD));
      end
      checks++;
      if (err_spacing !== (i >= 4 && i <= 10)) begin
        errors++; $display("FAIL drop_err +%0d: got %b want %b", i, err_spacing, (i >= 4 && i <= 10));
      end
    end
    checks++;
    if (drop_count !== 3'd1 || ack_count !== 3'd1) begin
      errors++; $display("FAIL drop_counts: got drop=%0d ack=%0d want 1 1", drop_count, ack_count);
    end
  endtask

  task automatic test_held();
    do_reset();
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    for (int i = 3; i <= 12; i++) begin
      cyc(0, 0);
      checks++;
      if (ack !== (i == AD)) begin
        errors++; $display("FAIL held_ack +%0d: got %b want %b", i, ack, (i == AD));
      end
    end
    checks++;
    if (drop_count !== 3'd2 || req_count !== 3'd1 || ack_count !== 3'd1) begin
      errors++;
      $display("FAIL held_counts: got drop=%0d req=%0d ack=%0d want 2 1 1", drop_count, req_count, ack_count);
    end
  endtask

  task automatic test_clr_vs_violation();
    do_reset();
    cyc(1, 0);
    cyc(1, 1);
    cyc(0, 0);
    checks++;
    if (err_spacing !== 1'b1) begin
      errors++; $display("FAIL clr_collide: got %b want 1", err_spacing);
    end
    cyc(0, 1);
    cyc(0, 0);
    checks++;
    if (err_spacing !== 1'b0) begin
      errors++; $display("FAIL clr_plain: got %b want 0", err_spacing);
    end
    repeat (MG) cyc(0, 0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ack, busy, err_spacing} !== 3'b000 || req_count !== 3'd0) begin
      errors++; $display("FAIL midrst_async: got flags=%b req=%0d want 000 0", {ack, busy, err_spacing}, req_count);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 1; i <= MG; i++) begin
      cyc(0, 0);
      checks++;
      if (ack !== 1'b0) begin
        errors++; $display("FAIL midrst_late_ack +%0d: got %b want 0", i, ack);
      end
    end
    cyc(1, 0);
    for (int i = 1; i <= MG; i++) begin
      cyc(0, 0);
      checks++;
      if (ack !== (i == AD)) begin
        errors++; $display("FAIL midrst_new_ack +%0d: got %b want %b", i, ack, (i == AD));
      end
    end
  endtask

  task automatic test_reset_during_ack();
    do_reset();
    cyc(1, 0);
    repeat (AD) cyc(0, 0);
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("FAIL rstack_pre: got %b want 1", ack);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("FAIL rstack_async: got %b want 0", ack);
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 1; i <= MG; i++) begin
      cyc(0, 0);
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rstack_after +%0d: got ack=%b busy=%b want 0 0", i, ack, busy);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int j = 0; j < 9; j++) begin
      cyc(1, 0);
      repeat (MG - 1) cyc(0, 0);
    end
    repeat (MG) cyc(0, 0);
    checks++;
    if (req_count !== 3'd1 || ack_count !== 3'd1 || drop_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_counts: got req=%0d ack=%0d drop=%0d want 1 1 0", req_count, ack_count, drop_count);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
    end
    repeat (MG) cyc(0, 0);
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_back_to_back();
    test_early_drop();
    test_held();
    test_clr_vs_violation();
    test_mid_reset();
    test_reset_during_ack();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
# req_ack_responder

Responder end of the single-pulse req/ack handshake. It samples one-cycle `req` pulses, returns a one-cycle `ack` exactly `ACK_DELAY` cycles later, and enforces the minimum request spacing. Requests that arrive too early are dropped and flagged. It sits opposite any initiator that drives `req`, and exports event counters for staged sim/formal checking.

## Interface
Parameters:
- `ACK_DELAY`, default 4: edges from the sampled `req` to the sampled `ack`; must be ≥ 1.
- `MIN_GAP`, default 8: minimum edge spacing between accepted requests; must be > `ACK_DELAY`.
- `CNT_W`, default 32: width of the event counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req`, in, 1: request pulse, sampled at rising edges.
- `err_clr`, in, 1: synchronous clear of `err_spacing`.
- `ack`, out, 1: acknowledge pulse, one cycle wide.
- `busy`, out, 1: a request is in service or in holdoff.
- `err_spacing`, out, 1: sticky spacing-violation flag.
- `req_count`, out, `CNT_W`: number of accepted requests.
- `ack_count`, out, `CNT_W`: number of acks issued.
- `drop_count`, out, `CNT_W`: number of dropped (early) requests.

## Operation
- FSM has two states: IDLE and BUSY. It holds one gap counter `cnt`, range 0..`MIN_GAP`-1.
- IDLE with `req`=1 at an edge: the request is accepted. State goes to BUSY, `cnt` becomes 1, and `req_count` increments.
- BUSY, every edge: `cnt` increments.
- BUSY with `cnt`==`MIN_GAP`-1: state returns to IDLE at that edge and `cnt` becomes 0.
- `ack` = (state==BUSY && `cnt`==`ACK_DELAY`). It is decoded from registers only and has no combinational path from `req`.
- `ack_count` increments on the edge where `ack` is sampled high.
- `req`=1 at an edge while BUSY is a spacing violation:
  - the request is dropped and produces no ack;
  - `drop_count` increments;
  - `err_spacing` is set;
  - the FSM and `cnt` are unaffected, so the in-flight ack still fires on time.
- `err_spacing` clears on an edge with `err_clr`=1 and no new violation on that edge. A simultaneous violation wins, so the flag stays set.
- Counters wrap modulo 2^`CNT_W`; they do not saturate.
- Invariant: at most one request is outstanding. `ack_count` ≤ `req_count` ≤ `ack_count`+1, modulo wrap.

## Timing
- `req` sampled high at edge k and accepted:
  - `ack` is high only in the cycle sampled at edge k+`ACK_DELAY` (k+4 by default);
  - `busy` is high from after edge k through edge k+`MIN_GAP`-1;
  - the earliest next accepted request is at edge k+`MIN_GAP` (k+8).
- `req` at edges k+1..k+`MIN_GAP`-1 is dropped.
- A `req` held high for several cycles is accepted once, then dropped on each following edge while BUSY.
- A `req` exactly at edge k+`MIN_GAP` is accepted with no gap cycle lost. The next ack is then at k+`MIN_GAP`+`ACK_DELAY`.
- Reset values: IDLE, `cnt`=0, `ack`=0, `busy`=0, `err_spacing`=0, all counters 0.
- `rst` asserted mid-operation immediately cancels any pending ack, with no late ack after release. `ack` drops asynchronously.
- The first edge after `rst` deasserts treats `req` as a fresh request in IDLE.

## Configuration
- Macro `REQ_ACK_RESP_FORMAL_EN`.
- When defined, embedded concurrent properties are compiled in, with deterministic `initial` values for formal:
  - assert `ack` implies `$past(req, ACK_DELAY)`;
  - assert `ack` is never high on two consecutive cycles;
  - assert the count invariant above;
  - cover `req_count`==2;
  - cover `drop_count`≥1.
- When undefined, there are no properties and no `initial` blocks, and the functional behaviour is identical.

## Structure
- Package `req_ack_pkg` holds:
  - the state enum (`REQ_ACK_IDLE`, `REQ_ACK_BUSY`);
  - default constants `REQ_ACK_DELAY_DEF`=4 and `REQ_ACK_MIN_GAP_DEF`=8;
  - a width function for `cnt` ($clog2(`MIN_GAP`)).
- One sub-module, `req_ack_gap_timer`, covers counter load, increment and terminal decode (`ack_hit`, `gap_done`). The FSM, violation logic and counters stay in the top level.

## Test plan
- Single `req` at edge 10 → `ack` sampled high only at edge 14; `busy` high for edges 11–17; `req_count`=1 and `ack_count`=1.
- `req` at edges 10 and 18 → acks at 14 and 22; `drop_count`=0 and `err_spacing`=0.
- `req` at 10 and 13 → one ack at 14; `drop_count`=1 and `err_spacing`=1. Then `err_clr` at 20 → `err_spacing`=0.
- `req` held high for edges 10–12 → one ack at 14; `drop_count`=2.
- `rst` pulsed at edge 12 after `req` at 10 → no ack at 14; all outputs 0. A `req` at 16 → ack at 20.
- With `CNT_W`=3 and 9 spaced requests → `req_count` and `ack_count` wrap to 1. Formal run with `REQ_ACK_RESP_FORMAL_EN` defined → all asserts pass and both covers are reached.
